// File: rtl/riscv_m_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package riscv_m_pkg;

    localparam int M_XLEN         = 32;
    localparam int MULDIV_LATENCY = M_XLEN + 2;

    // funct3 encodings of the RV32M instructions
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } m_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request / write-back bundle between the issue stage and the mul/div unit.
interface muldiv_unit_if #(parameter int XLEN = 32);

    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] readdata_1;
    logic [XLEN-1:0] readdata_2;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [4:0]      rd;
    logic [XLEN-1:0] writedata;
    logic            write;

    // Requester side (pipeline / testbench)
    modport master (
        output start, kill, funct3, readdata_1, readdata_2, rd_in,
        input  busy, done, rd, writedata, write
    );

    // Execution unit side
    modport slave (
        input  start, kill, funct3, readdata_1, readdata_2, rd_in,
        output busy, done, rd, writedata, write
    );

endinterface

// File: rtl/muldiv_core.sv
// Shared 2*XLEN-bit datapath: shift-add multiply or restoring divide, one bit per step.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [2*XLEN-1:0] load_acc,
    input  logic [XLEN-1:0]   load_opnd,
    output logic [2*XLEN-1:0] acc
);

    // Multiply: acc = {partial product high, multiplier shifting out}, opnd = multiplicand.
    // Divide:   acc = {partial remainder, dividend shifting in quotient bits}, opnd = divisor.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_diff;

    // Next accumulator value for a load or a single iteration
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = acc_q[2*XLEN-1:XLEN-1];
        // Only needed when rem_shift >= divisor, where the result fits in XLEN bits
        rem_diff  = rem_shift[XLEN-1:0] - opnd_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        if (load) begin
            acc_d  = load_acc;
            opnd_d = load_opnd;
        end else if (step) begin
            if (is_div) begin
                if (rem_shift >= {1'b0, opnd_q}) begin
                    acc_d = {rem_diff, acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed XLEN+2 cycle latency.
module muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int XLEN = M_XLEN
) (
    input  logic           clk,
    input  logic           reset_n,
    muldiv_unit_if.slave   bus
);

    localparam logic [4:0] CNT_INIT = 5'(XLEN - 1);

    muldiv_state_t     state_q, state_d;
    m_op_t             op_q, op_d;
    logic [4:0]        rd_lat_q, rd_lat_d;
    logic [4:0]        count_q, count_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div_zero_q, div_zero_d;
    logic              done_q, done_d;

    logic              is_div;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              core_load, core_step;
    logic [2*XLEN-1:0] core_load_acc;
    logic [XLEN-1:0]   core_load_opnd;
    logic [2*XLEN-1:0] core_acc;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s;
    logic [XLEN-1:0]   result;

    assign is_div = op_q[2];

    // Operand magnitudes and result selection with sign correction
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        case (op_q)
            OP_MULH, OP_DIV, OP_REM: begin
                a_neg = a_q[XLEN-1];
                b_neg = b_q[XLEN-1];
            end
            OP_MULHSU: a_neg = a_q[XLEN-1];
            default: ;
        endcase
        mag_a = a_neg ? ('0 - a_q) : a_q;
        mag_b = b_neg ? ('0 - b_q) : b_q;

        // Dividend enters the low half; for multiply rs2 is the shifted multiplier
        core_load_acc  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
        core_load_opnd = is_div ? mag_b : mag_a;

        prod_s = neg_res_q ? ('0 - core_acc) : core_acc;
        quot_s = neg_res_q ? ('0 - core_acc[XLEN-1:0]) : core_acc[XLEN-1:0];
        rem_s  = neg_rem_q ? ('0 - core_acc[2*XLEN-1:XLEN]) : core_acc[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:          result = prod_s[XLEN-1:0];
            OP_DIV, OP_DIVU: result = div_zero_q ? '1 : quot_s;
            OP_REM, OP_REMU: result = div_zero_q ? a_q : rem_s;
            default:         result = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    // FSM next-state and register updates
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_lat_d   = rd_lat_q;
        count_d    = count_q;
        rd_d       = rd_q;
        a_d        = a_q;
        b_d        = b_q;
        wdata_d    = wdata_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        core_load  = 1'b0;
        core_step  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.kill) begin
                    op_d     = m_op_t'(bus.funct3);
                    rd_lat_d = bus.rd_in;
                    a_d      = bus.readdata_1;
                    b_d      = bus.readdata_2;
                    state_d  = PREP;
                end
            end
            PREP: begin
                neg_res_d  = a_neg ^ b_neg;
                neg_rem_d  = a_neg;
                div_zero_d = (b_q == '0);
                core_load  = 1'b1;
                count_d    = CNT_INIT;
                state_d    = CALC;
            end
            CALC: begin
                core_step = 1'b1;
                count_d   = count_q - 5'd1;
                if (count_q == 5'd0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                wdata_d = result;
                rd_d    = rd_lat_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush: abandon the op without touching the write-back registers
        if (bus.kill && state_q != IDLE) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            rd_d      = rd_q;
            wdata_d   = wdata_q;
            core_load = 1'b0;
            core_step = 1'b0;
        end
    end

    // State and data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= OP_MUL;
            rd_lat_q   <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            wdata_q    <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_lat_q   <= rd_lat_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wdata_q    <= wdata_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst_n     (reset_n),
        .load      (core_load),
        .step      (core_step),
        .is_div    (is_div),
        .load_acc  (core_load_acc),
        .load_opnd (core_load_opnd),
        .acc       (core_acc)
    );

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.rd        = rd_q;
    assign bus.writedata = wdata_q;
    assign bus.write     = done_q && (rd_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import riscv_m_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request before an edge; returns #1 after the accepting edge E0
    task automatic issue(input m_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rdi);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.funct3     = op;
        bus.readdata_1 = a;
        bus.readdata_2 = b;
        bus.rd_in      = rdi;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.readdata_1 = $urandom();
        bus.readdata_2 = $urandom();
        bus.rd_in      = 5'($urandom_range(0, 31));
        chk("accept_busy", 32'(bus.busy), 32'd1);
        chk("accept_nodone", 32'(bus.done), 32'd0);
    endtask

    // pre = edges still to go until E0+XLEN+1; done must appear right after the next edge
    task automatic expect_result(input string tag, input logic [31:0] exp,
                                 input logic [4:0] rdi, input int pre);
        repeat (pre) @(posedge clk);
        #1;
        chk({tag, "_early"}, 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_data"}, bus.writedata, exp);
        chk({tag, "_rd"}, 32'(bus.rd), 32'(rdi));
        chk({tag, "_write"}, 32'(bus.write), 32'(rdi != 5'd0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        $display("op %s result=%h rd=%0d write=%0d", tag, bus.writedata, bus.rd, bus.write);
    endtask

    task automatic no_done(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    localparam int PRE = MULDIV_LATENCY - 1;

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.kill       = 1'b0;
        bus.funct3     = 3'd0;
        bus.readdata_1 = '0;
        bus.readdata_2 = '0;
        bus.rd_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_rd", 32'(bus.rd), 32'd0);
        chk("rst_wdata", bus.writedata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Multiplies, each issued back-to-back in the previous done cycle
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        expect_result("mul", 32'hFFFF_FFEB, 5'd5, PRE);
        issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6);
        expect_result("mulh", 32'h4000_0000, 5'd6, PRE);
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        expect_result("mulhu", 32'hFFFF_FFFE, 5'd7, PRE);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
        expect_result("mulhsu", 32'hFFFF_FFFF, 5'd8, PRE);

        // Divides including divide-by-zero and signed overflow
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10);
        expect_result("div", 32'hFFFF_FFFD, 5'd10, PRE);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
        expect_result("rem", 32'hFFFF_FFFF, 5'd11, PRE);
        issue(OP_DIVU, 32'd5, 32'd0, 5'd12);
        expect_result("divu_z", 32'hFFFF_FFFF, 5'd12, PRE);
        issue(OP_REMU, 32'd5, 32'd0, 5'd13);
        expect_result("remu_z", 32'd5, 5'd13, PRE);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd14);
        expect_result("div_z", 32'hFFFF_FFFF, 5'd14, PRE);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd15);
        expect_result("rem_z", 32'hFFFF_FFF9, 5'd15, PRE);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        expect_result("div_ovf", 32'h8000_0000, 5'd16, PRE);
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
        expect_result("rem_ovf", 32'd0, 5'd17, PRE);

        // start while busy is ignored
        issue(OP_DIVU, 32'd100, 32'd7, 5'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.funct3     = OP_MUL;
        bus.readdata_1 = 32'd2;
        bus.readdata_2 = 32'd2;
        bus.rd_in      = 5'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ign_busy", 32'(bus.busy), 32'd1);
        expect_result("divu_ign", 32'd14, 5'd3, PRE - 5);
        // kill and start together in the done cycle: pulse stays, start dropped
        bus.kill  = 1'b1;
        bus.start = 1'b1;
        #1;
        chk("kill_done_pulse", 32'(bus.done), 32'd1);
        @(posedge clk);
        #1;
        bus.kill  = 1'b0;
        bus.start = 1'b0;
        chk("kill_start_drop", 32'(bus.busy), 32'd0);
        no_done("ign_no_second", 40);

        // kill mid-operation
        issue(OP_MUL, 32'd3, 32'd3, 5'd4);
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        chk("kill_busy", 32'(bus.busy), 32'd0);
        no_done("kill_no_done", 40);

        // rd_in = 0: done pulses but no register write
        issue(OP_MUL, 32'd3, 32'd4, 5'd0);
        expect_result("mul_rd0", 32'd12, 5'd0, PRE);

        // asynchronous reset in the middle of CALC
        issue(OP_MUL, 32'd7, 32'd3, 5'd1);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_wdata", bus.writedata, 32'd0);
        chk("mrst_rd", 32'(bus.rd), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        no_done("mrst_no_done", 40);
        issue(OP_MUL, 32'd7, 32'd3, 5'd1);
        expect_result("mul_after_rst", 32'd21, 5'd1, PRE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two operand words read from reg_file (readdata_1 / readdata_2) plus the destination index.
- After a fixed multi-cycle latency, produces a one-cycle write port (rd, writedata, write) that drives reg_file's write side directly.
- The pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width; fixed latency = XLEN+2 cycles.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- kill  input  1  synchronous abort of in-flight op (pipeline flush)
- funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- readdata_1  input  XLEN  rs1 operand
- readdata_2  input  XLEN  rs2 operand
- rd_in  input  5  destination register index
- busy  output  1  op in flight; start ignored while high
- done  output  1  one-cycle completion pulse
- rd  output  5  destination index, to reg_file
- writedata  output  XLEN  result, to reg_file
- write  output  1  reg_file write enable, equals done AND (rd!=0)

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, write=0, rd=0, writedata=0; all internal registers cleared. Reset mid-operation aborts with no done.
- States:
  - IDLE: on start=1 at edge E0, latch funct3, rd_in and operands; go to PREP; busy=1 from E0.
  - PREP (1 cycle): compute operand magnitudes per signedness and record result sign.
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both operands signed.
    - Others: unsigned.
  - CALC (XLEN cycles, 5-bit down-counter XLEN-1..0):
    - Multiply: shift-add, 2*XLEN-bit product.
    - Divide: restoring shift-subtract, one quotient bit per cycle.
    - Counter==0 goes to FIN.
  - FIN (1 cycle):
    - Apply sign correction (two's-complement negate of product/quotient if signs differ; remainder takes dividend sign).
    - Select low word (MUL) or high word (MULH*), quotient or remainder.
    - Register writedata and rd; go to IDLE.
- Timing after start accepted at E0:
  - done=1 (and write if rd!=0) for exactly the cycle following edge E0+XLEN+2.
  - busy falls at that same edge.
  - writedata and rd hold until the next completion.
- Back-to-back: start may be high in the done cycle (busy=0) and is accepted; the next result follows XLEN+2 cycles later.
- start while busy=1: ignored, no state effect.
- Divide by zero (no trap), fixed latency unchanged:
  - DIV/DIVU → all ones.
  - REM/REMU → dividend.
- Signed overflow (0x80000000 / -1), fixed latency unchanged:
  - DIV → 0x80000000.
  - REM → 0.
- kill=1 in any non-IDLE state: next edge returns to IDLE, busy=0, no done/write.
  - kill in the done cycle does not suppress the pulse already present.
  - kill and start in the same IDLE cycle: start is dropped.
- rd_in=0: op runs and done pulses; write stays 0.
- Operands are sampled only at acceptance; input changes during busy are irrelevant.

Decomposition:
- Package riscv_m_pkg:
  - m_op_t enum for the funct3 encodings.
  - muldiv_state_t enum {IDLE, PREP, CALC, FIN}.
  - MULDIV_LATENCY = XLEN+2 constant.
- One sub-module, muldiv_core:
  - Holds the shared 2*XLEN-bit accumulator/remainder register and the per-cycle add-or-subtract step.
  - Selected by an is_div bit.
  - Top level keeps the FSM, sign handling and output registers.

Test Plan:
- Reset mid-CALC (reset_n low at E0+10) → outputs 0 immediately, no done ever; a following MUL 7×3 returns 21 at E0'+34.
- MUL 7×0xFFFFFFFD, rd=5 → writedata=0xFFFFFFEB, rd=5, write=1, done exactly 34 cycles after accept.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division results:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- start pulsed at E0+5 while busy with different operands → ignored; first result is unaffected and no second done appears.
- kill at E0+12 → busy low next cycle, no done.
  - Back-to-back start in a done cycle → second result 34 cycles later.
- rd_in=0 with MUL 3×4 → done=1, writedata=12, write=0.
